// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer: op codes, FSM states,
// flag bit positions, enable indices and the decoder result record.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ADC = 4'd0, SBC = 4'd1, AND = 4'd2, EOR = 4'd3, ORA = 4'd4, ASL = 4'd5,
        LSR = 4'd6, ROL = 4'd7, ROR = 4'd8, CMP = 4'd9, INC = 4'd10, DEC = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} seq_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] MASK_NVZC = 4'b1111;
    localparam logic [3:0] MASK_NZC  = 4'b1011;
    localparam logic [3:0] MASK_NZ   = 4'b1010;

    localparam int EN_W   = 9;
    localparam int EN_SUM = 0;
    localparam int EN_AND = 1;
    localparam int EN_EOR = 2;
    localparam int EN_OR  = 3;
    localparam int EN_ASL = 4;
    localparam int EN_LSR = 5;
    localparam int EN_INV = 6;
    localparam int EN_ROL = 7;
    localparam int EN_ROR = 8;

    typedef enum logic [1:0] {A_SEL_ZERO, A_SEL_A, A_SEL_B} a_sel_t;
    typedef enum logic [2:0] {B_SEL_ZERO, B_SEL_B, B_SEL_TMP, B_SEL_ONE, B_SEL_FF} b_sel_t;
    typedef enum logic [1:0] {C_SEL_ZERO, C_SEL_CIN, C_SEL_ONE} c_sel_t;

    typedef struct packed {
        logic [EN_W-1:0] en;
        a_sel_t          a_sel;
        b_sel_t          b_sel;
        c_sel_t          c_sel;
        logic [3:0]      mask;
        logic            wr;
        logic            two_pass;
        logic            illegal;
    } decode_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake plus the ALU control and result bus.
// The slave side is the sequencer; the master side is the CPU control path
// together with the ALU datapath.
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cin;
    logic       SUM_en, AND_en, EOR_en, OR_en, ASL_en, LSR_en, INV_en, ROL_en, ROR_en;
    logic [7:0] Ain;
    logic [7:0] Bin;
    logic       Cin;
    logic [7:0] RES;
    logic       Cout;
    logic       OVFout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_res;
    logic       rsp_wr;
    logic [3:0] rsp_flags;
    logic [3:0] rsp_mask;
    logic       rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, RES, Cout, OVFout, rsp_ready,
        output req_ready, SUM_en, AND_en, EOR_en, OR_en, ASL_en, LSR_en, INV_en, ROL_en, ROR_en,
        output Ain, Bin, Cin, rsp_valid, rsp_res, rsp_wr, rsp_flags, rsp_mask, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, RES, Cout, OVFout, rsp_ready,
        input  req_ready, SUM_en, AND_en, EOR_en, OR_en, ASL_en, LSR_en, INV_en, ROL_en, ROR_en,
        input  Ain, Bin, Cin, rsp_valid, rsp_res, rsp_wr, rsp_flags, rsp_mask, rsp_err
    );
endinterface

// File: rtl/alu_sequencer_decode.sv
// Pure combinational op decoder: given an op code and the pass number it
// picks the single ALU enable, where Ain/Bin/Cin come from, which flags the
// op updates and whether the result is written back.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    input  logic       pass,
    output decode_t    dec
);

    // Translate (op, pass) into ALU control and response attributes
    always_comb begin
        dec.en       = '0;
        dec.a_sel    = A_SEL_ZERO;
        dec.b_sel    = B_SEL_ZERO;
        dec.c_sel    = C_SEL_ZERO;
        dec.mask     = 4'b0000;
        dec.wr       = 1'b0;
        dec.two_pass = 1'b0;
        dec.illegal  = 1'b0;
        case (op)
            ADC: begin
                dec.en[EN_SUM] = 1'b1;
                dec.a_sel      = A_SEL_A;
                dec.b_sel      = B_SEL_B;
                dec.c_sel      = C_SEL_CIN;
                dec.mask       = MASK_NVZC;
                dec.wr         = 1'b1;
            end
            SBC, CMP: begin
                dec.two_pass = 1'b1;
                if (!pass) begin
                    dec.en[EN_INV] = 1'b1;
                    dec.a_sel      = A_SEL_B;
                end else begin
                    dec.en[EN_SUM] = 1'b1;
                    dec.a_sel      = A_SEL_A;
                    dec.b_sel      = B_SEL_TMP;
                    if (op == CMP) dec.c_sel = C_SEL_ONE;
                    else           dec.c_sel = C_SEL_CIN;
                end
                dec.mask = (op == CMP) ? MASK_NZC : MASK_NVZC;
                dec.wr   = (op != CMP);
            end
            AND, EOR, ORA: begin
                if (op == AND)      dec.en[EN_AND] = 1'b1;
                else if (op == EOR) dec.en[EN_EOR] = 1'b1;
                else                dec.en[EN_OR]  = 1'b1;
                dec.a_sel = A_SEL_A;
                dec.b_sel = B_SEL_B;
                dec.mask  = MASK_NZ;
                dec.wr    = 1'b1;
            end
            ASL, LSR, ROL, ROR: begin
                if (op == ASL)      dec.en[EN_ASL] = 1'b1;
                else if (op == LSR) dec.en[EN_LSR] = 1'b1;
                else if (op == ROL) dec.en[EN_ROL] = 1'b1;
                else                dec.en[EN_ROR] = 1'b1;
                dec.a_sel = A_SEL_A;
                dec.c_sel = C_SEL_CIN;
                dec.mask  = MASK_NZC;
                dec.wr    = 1'b1;
            end
            INC, DEC: begin
                dec.en[EN_SUM] = 1'b1;
                dec.a_sel      = A_SEL_A;
                dec.b_sel      = (op == INC) ? B_SEL_ONE : B_SEL_FF;
                dec.mask       = MASK_NZ;
                dec.wr         = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer top: accepts one request at a time, drives the ALU for one
// or two passes, captures result and flags, and holds the response until the
// consumer takes it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter bit ILLEGAL_ERR = 1'b1
) (
    input logic      clk,
    input logic      rst,
    alu_sequencer_if.slave bus
);

    seq_state_t      state;
    logic [3:0]      op_q;
    logic [7:0]      a_q, b_q;
    logic            cin_q;
    logic [EN_W-1:0] en_q;
    logic [7:0]      ain_q, bin_q;
    logic            cin_out_q;
    logic            req_ready_q, rsp_valid_q, rsp_wr_q, rsp_err_q;
    logic [7:0]      rsp_res_q;
    logic [3:0]      rsp_flags_q, rsp_mask_q;

    logic [3:0]      dec_op;
    logic            dec_pass;
    decode_t         dec;
    logic [7:0]      opnd_a, opnd_b;
    logic            opnd_cin;
    logic [7:0]      ain_nxt, bin_nxt;
    logic            cin_nxt;
    logic [3:0]      flags_raw;

    // While idle, decode the incoming request; afterwards the latched op's next pass
    always_comb begin
        dec_op   = op_q;
        opnd_a   = a_q;
        opnd_b   = b_q;
        opnd_cin = cin_q;
        dec_pass = (state != IDLE);
        if (state == IDLE) begin
            dec_op   = bus.req_op;
            opnd_a   = bus.req_a;
            opnd_b   = bus.req_b;
            opnd_cin = bus.req_cin;
        end
    end

    alu_seq_decode u_decode (
        .op   (dec_op),
        .pass (dec_pass),
        .dec  (dec)
    );

    // Steer the decoded operand sources onto the next-cycle ALU inputs
    always_comb begin
        ain_nxt = 8'h00;
        bin_nxt = 8'h00;
        cin_nxt = 1'b0;
        case (dec.a_sel)
            A_SEL_A: ain_nxt = opnd_a;
            A_SEL_B: ain_nxt = opnd_b;
            default: ain_nxt = 8'h00;
        endcase
        case (dec.b_sel)
            B_SEL_B:   bin_nxt = opnd_b;
            B_SEL_TMP: bin_nxt = bus.RES;
            B_SEL_ONE: bin_nxt = 8'h01;
            B_SEL_FF:  bin_nxt = 8'hFF;
            default:   bin_nxt = 8'h00;
        endcase
        case (dec.c_sel)
            C_SEL_CIN: cin_nxt = opnd_cin;
            C_SEL_ONE: cin_nxt = 1'b1;
            default:   cin_nxt = 1'b0;
        endcase
    end

    // N/V/Z/C as produced by the pass currently executing on the ALU
    always_comb begin
        flags_raw         = 4'b0000;
        flags_raw[FLAG_N] = bus.RES[7];
        flags_raw[FLAG_V] = bus.OVFout;
        flags_raw[FLAG_Z] = (bus.RES == 8'h00);
        flags_raw[FLAG_C] = bus.Cout;
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= 4'h0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            cin_q       <= 1'b0;
            en_q        <= '0;
            ain_q       <= 8'h00;
            bin_q       <= 8'h00;
            cin_out_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= 8'h00;
            rsp_flags_q <= 4'h0;
            rsp_mask_q  <= 4'h0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        op_q        <= bus.req_op;
                        a_q         <= bus.req_a;
                        b_q         <= bus.req_b;
                        cin_q       <= bus.req_cin;
                        req_ready_q <= 1'b0;
                        if (dec.illegal) begin
                            state       <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_res_q   <= bus.req_a;
                            rsp_flags_q <= 4'h0;
                            rsp_mask_q  <= 4'h0;
                            rsp_wr_q    <= 1'b0;
                            rsp_err_q   <= ILLEGAL_ERR;
                        end else begin
                            state     <= EXEC1;
                            en_q      <= dec.en;
                            ain_q     <= ain_nxt;
                            bin_q     <= bin_nxt;
                            cin_out_q <= cin_nxt;
                        end
                    end
                end
                EXEC1, EXEC2: begin
                    if (state == EXEC1 && dec.two_pass) begin
                        state     <= EXEC2;
                        en_q      <= dec.en;
                        ain_q     <= ain_nxt;
                        bin_q     <= bin_nxt;
                        cin_out_q <= cin_nxt;
                    end else begin
                        state       <= DONE;
                        en_q        <= '0;
                        ain_q       <= 8'h00;
                        bin_q       <= 8'h00;
                        cin_out_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_res_q   <= bus.RES;
                        rsp_flags_q <= flags_raw & dec.mask;
                        rsp_mask_q  <= dec.mask;
                        rsp_wr_q    <= dec.wr;
                        rsp_err_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_res_q   <= 8'h00;
                        rsp_flags_q <= 4'h0;
                        rsp_mask_q  <= 4'h0;
                        rsp_wr_q    <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.SUM_en    = en_q[EN_SUM];
    assign bus.AND_en    = en_q[EN_AND];
    assign bus.EOR_en    = en_q[EN_EOR];
    assign bus.OR_en     = en_q[EN_OR];
    assign bus.ASL_en    = en_q[EN_ASL];
    assign bus.LSR_en    = en_q[EN_LSR];
    assign bus.INV_en    = en_q[EN_INV];
    assign bus.ROL_en    = en_q[EN_ROL];
    assign bus.ROR_en    = en_q[EN_ROR];
    assign bus.Ain       = ain_q;
    assign bus.Bin       = bin_q;
    assign bus.Cin       = cin_out_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_wr    = rsp_wr_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_mask  = rsp_mask_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a bit-level ALU stands in for the datapath, a
// table of hand-derived vectors and random ops scored by an arithmetic
// reference model, plus directed enable-routing and reset sequences.
`timescale 1ns/1ps
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        int         hold;
        logic [7:0] res;
        logic [3:0] flags;
        logic [3:0] mask;
        logic       wr;
        logic       err;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic started = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [8:0] seen_en  [0:9];
    logic [7:0] seen_ain [0:9];
    logic [7:0] seen_bin [0:9];
    logic       seen_cin [0:9];

    alu_sequencer_if bus();

    alu_sequencer #(.ILLEGAL_ERR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] en_vec;
    assign en_vec = {bus.ROR_en, bus.ROL_en, bus.INV_en, bus.LSR_en, bus.ASL_en,
                     bus.OR_en, bus.EOR_en, bus.AND_en, bus.SUM_en};

    // Bit-level ALU standing in for the real datapath
    logic [7:0] alu_res;
    logic       alu_c, alu_v;
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, bus.Ain} + {1'b0, bus.Bin} + {8'h00, bus.Cin};
        alu_res = 8'h00;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (bus.SUM_en) begin
            alu_res = alu_sum[7:0];
            alu_c   = alu_sum[8];
            alu_v   = (bus.Ain[7] == bus.Bin[7]) && (alu_sum[7] != bus.Ain[7]);
        end else if (bus.AND_en) alu_res = bus.Ain & bus.Bin;
        else if (bus.EOR_en)     alu_res = bus.Ain ^ bus.Bin;
        else if (bus.OR_en)      alu_res = bus.Ain | bus.Bin;
        else if (bus.INV_en)     alu_res = ~bus.Ain;
        else if (bus.ASL_en) begin alu_res = {bus.Ain[6:0], 1'b0};    alu_c = bus.Ain[7]; end
        else if (bus.LSR_en) begin alu_res = {1'b0, bus.Ain[7:1]};    alu_c = bus.Ain[0]; end
        else if (bus.ROL_en) begin alu_res = {bus.Ain[6:0], bus.Cin}; alu_c = bus.Ain[7]; end
        else if (bus.ROR_en) begin alu_res = {bus.Cin, bus.Ain[7:1]}; alu_c = bus.Ain[0]; end
    end
    assign bus.RES    = alu_res;
    assign bus.Cout   = alu_c;
    assign bus.OVFout = alu_v;

    // Every cycle: at most one enable, and quiet ALU inputs whenever idle or responding
    always @(negedge clk) begin
        if (started && !rst) begin
            checks++;
            if ($countones(en_vec) > 1) begin
                errors++;
                $display("[TB] FAIL onehot: enables=%b, required at most one set", en_vec);
            end
            if (bus.rsp_valid || bus.req_ready) begin
                checks++;
                if (en_vec != 9'h000 || bus.Ain != 8'h00 || bus.Bin != 8'h00 || bus.Cin != 1'b0) begin
                    errors++;
                    $display("[TB] FAIL quiet_alu: en=%b Ain=%h Bin=%h Cin=%b, required all zero",
                             en_vec, bus.Ain, bus.Bin, bus.Cin);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic cin, int hold,
                                   logic [7:0] res, logic [3:0] flags, logic [3:0] mask,
                                   logic wr, logic err, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = cin; v.hold = hold;
        v.res = res; v.flags = flags; v.mask = mask; v.wr = wr; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Arithmetic reference: what each op means on integers, not how the hardware does it
    function automatic vec_t refModel(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic cin, int hold);
        vec_t v;
        int   ua, ub, sa, sb, ci, full, sfull, r;
        logic n, ov, z, c;
        ua = int'(a); ub = int'(b); ci = int'(cin);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        v.op = op; v.a = a; v.b = b; v.cin = cin; v.hold = hold;
        v.wr = 1'b1; v.err = 1'b0; v.lat = 2; v.mask = 4'b1010;
        c = 1'b0; ov = 1'b0; r = 0;
        case (op)
            4'd0: begin
                full = ua + ub + ci; sfull = sa + sb + ci;
                r = full % 256; c = (full > 255); ov = (sfull > 127) || (sfull < -128);
                v.mask = 4'b1111;
            end
            4'd1, 4'd9: begin
                if (op == 4'd1) begin
                    full = ua - ub - (1 - ci); sfull = sa - sb - (1 - ci); v.mask = 4'b1111;
                end else begin
                    full = ua - ub; sfull = sa - sb; v.mask = 4'b1011; v.wr = 1'b0;
                end
                r = (full + 512) % 256; c = (full >= 0); ov = (sfull > 127) || (sfull < -128);
                v.lat = 3;
            end
            4'd2:  r = int'(a & b);
            4'd3:  r = int'(a ^ b);
            4'd4:  r = int'(a | b);
            4'd5:  begin r = (ua * 2) % 256;        c = (ua >= 128);  v.mask = 4'b1011; end
            4'd6:  begin r = ua / 2;                c = (ua % 2 == 1); v.mask = 4'b1011; end
            4'd7:  begin r = (ua * 2) % 256 + ci;   c = (ua >= 128);  v.mask = 4'b1011; end
            4'd8:  begin r = ua / 2 + ci * 128;     c = (ua % 2 == 1); v.mask = 4'b1011; end
            4'd10: r = (ua + 1) % 256;
            4'd11: r = (ua + 255) % 256;
            default: begin r = ua; v.mask = 4'b0000; v.wr = 1'b0; v.err = 1'b1; v.lat = 1; end
        endcase
        n = (r >= 128);
        z = (r == 0);
        v.res   = 8'(r);
        v.flags = {n, ov, z, c} & v.mask;
        return v;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One full transaction: handshake, latency, response fields, backpressure, release
    task automatic applyStimulus(input vec_t v, input string name);
        int k;
        int en_cycles;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, " req_ready"}, int'(bus.req_ready), 1);
        if (!bus.req_ready) begin
            doReset();
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_cin   = v.cin;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_a     = ~v.a;
        bus.req_b     = ~v.b;
        bus.req_cin   = ~v.cin;
        k = 1;
        en_cycles = 0;
        while (!bus.rsp_valid && k < 9) begin
            if (en_vec != 9'h000) en_cycles++;
            seen_en[k]  = en_vec;
            seen_ain[k] = bus.Ain;
            seen_bin[k] = bus.Bin;
            seen_cin[k] = bus.Cin;
            @(negedge clk);
            k++;
        end
        checkOutput({name, " latency"}, k, v.lat);
        if (!bus.rsp_valid) begin
            doReset();
            return;
        end
        checkOutput({name, " enable_cycles"}, en_cycles, v.lat - 1);
        checkOutput({name, " rsp_res"},   int'(bus.rsp_res),   int'(v.res));
        checkOutput({name, " rsp_flags"}, int'(bus.rsp_flags), int'(v.flags));
        checkOutput({name, " rsp_mask"},  int'(bus.rsp_mask),  int'(v.mask));
        checkOutput({name, " rsp_wr"},    int'(bus.rsp_wr),    int'(v.wr));
        checkOutput({name, " rsp_err"},   int'(bus.rsp_err),   int'(v.err));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            checkOutput({name, " hold rsp_valid"}, int'(bus.rsp_valid), 1);
            checkOutput({name, " hold rsp_res"},   int'(bus.rsp_res),   int'(v.res));
            checkOutput({name, " hold rsp_flags"}, int'(bus.rsp_flags), int'(v.flags));
            checkOutput({name, " hold req_ready"}, int'(bus.req_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        checkOutput({name, " no accept in DONE"}, int'(bus.req_ready), 0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput({name, " released rsp_valid"}, int'(bus.rsp_valid), 0);
        checkOutput({name, " released req_ready"}, int'(bus.req_ready), 1);
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        vec_t vecs[16];
        vec_t v;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;

        vecs[0]  = mkVec(ADC,   8'h50, 8'h50, 1'b0, 0, 8'hA0, 4'b1100, 4'hF, 1'b1, 1'b0, 2);
        vecs[1]  = mkVec(SBC,   8'h50, 8'h30, 1'b1, 0, 8'h20, 4'b0001, 4'hF, 1'b1, 1'b0, 3);
        vecs[2]  = mkVec(CMP,   8'h10, 8'h10, 1'b0, 1, 8'h00, 4'b0011, 4'hB, 1'b0, 1'b0, 3);
        vecs[3]  = mkVec(ASL,   8'hAA, 8'h00, 1'b1, 0, 8'h54, 4'b0001, 4'hB, 1'b1, 1'b0, 2);
        vecs[4]  = mkVec(LSR,   8'hAA, 8'h00, 1'b1, 0, 8'h55, 4'b0000, 4'hB, 1'b1, 1'b0, 2);
        vecs[5]  = mkVec(ROL,   8'hAA, 8'h00, 1'b1, 0, 8'h55, 4'b0001, 4'hB, 1'b1, 1'b0, 2);
        vecs[6]  = mkVec(ROR,   8'hAA, 8'h00, 1'b1, 0, 8'hD5, 4'b1000, 4'hB, 1'b1, 1'b0, 2);
        vecs[7]  = mkVec(ORA,   8'h0F, 8'hF0, 1'b0, 5, 8'hFF, 4'b1000, 4'hA, 1'b1, 1'b0, 2);
        vecs[8]  = mkVec(AND,   8'hF0, 8'h3C, 1'b1, 0, 8'h30, 4'b0000, 4'hA, 1'b1, 1'b0, 2);
        vecs[9]  = mkVec(EOR,   8'hFF, 8'hFF, 1'b0, 0, 8'h00, 4'b0010, 4'hA, 1'b1, 1'b0, 2);
        vecs[10] = mkVec(INC,   8'hFF, 8'h12, 1'b1, 0, 8'h00, 4'b0010, 4'hA, 1'b1, 1'b0, 2);
        vecs[11] = mkVec(DEC,   8'h00, 8'h12, 1'b1, 0, 8'hFF, 4'b1000, 4'hA, 1'b1, 1'b0, 2);
        vecs[12] = mkVec(4'hE,  8'h33, 8'h77, 1'b1, 2, 8'h33, 4'b0000, 4'h0, 1'b0, 1'b1, 1);
        vecs[13] = mkVec(SBC,   8'h00, 8'h01, 1'b1, 0, 8'hFF, 4'b1000, 4'hF, 1'b1, 1'b0, 3);
        vecs[14] = mkVec(ADC,   8'h7F, 8'h01, 1'b0, 0, 8'h80, 4'b1100, 4'hF, 1'b1, 1'b0, 2);
        vecs[15] = mkVec(CMP,   8'h05, 8'h10, 1'b1, 0, 8'hF5, 4'b1000, 4'hB, 1'b0, 1'b0, 3);

        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", int'(bus.req_ready), 1);
        checkOutput("reset rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("reset enables",   int'(en_vec), 0);
        checkOutput("reset Ain",       int'(bus.Ain), 0);
        checkOutput("reset rsp_res",   int'(bus.rsp_res), 0);
        checkOutput("reset rsp_err",   int'(bus.rsp_err), 0);
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        applyStimulus(vecs[0], "adc route");
        checkOutput("adc exec1 en",  int'(seen_en[1]),  'h001);
        checkOutput("adc exec1 Ain", int'(seen_ain[1]), 'h50);
        checkOutput("adc exec1 Bin", int'(seen_bin[1]), 'h50);
        checkOutput("adc exec1 Cin", int'(seen_cin[1]), 0);

        applyStimulus(vecs[1], "sbc route");
        checkOutput("sbc exec1 en",  int'(seen_en[1]),  'h040);
        checkOutput("sbc exec1 Ain", int'(seen_ain[1]), 'h30);
        checkOutput("sbc exec2 en",  int'(seen_en[2]),  'h001);
        checkOutput("sbc exec2 Ain", int'(seen_ain[2]), 'h50);
        checkOutput("sbc exec2 Bin", int'(seen_bin[2]), 'hCF);
        checkOutput("sbc exec2 Cin", int'(seen_cin[2]), 1);

        applyStimulus(vecs[2], "cmp route");
        checkOutput("cmp exec2 Cin", int'(seen_cin[2]), 1);

        bus.req_valid = 1'b1;
        bus.req_op    = SBC;
        bus.req_a     = 8'h50;
        bus.req_b     = 8'h30;
        bus.req_cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("rstseq exec1 en", int'(en_vec), 'h040);
        @(negedge clk);
        checkOutput("rstseq exec2 en", int'(en_vec), 'h001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstseq enables",   int'(en_vec), 0);
        checkOutput("rstseq rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("rstseq req_ready", int'(bus.req_ready), 1);
        @(negedge clk);
        checkOutput("rstseq lost rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("rstseq idle req_ready", int'(bus.req_ready), 1);

        for (int i = 0; i < 60; i++) begin
            v = refModel(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                         1'($urandom), int'($urandom_range(0, 2)));
            applyStimulus(v, $sformatf("rand%0d op%0d a%02h b%02h c%0d", i, v.op, v.a, v.b, v.cin));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
